// File: rtl/bowling_pkg.sv
// rtl/bowling_pkg.sv - shared types and game constants for the launcher and ball blocks
package bowling_pkg;

  typedef enum logic [2:0] {
    ST_AIM       = 3'd0,
    ST_POWER     = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_ROLLING   = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_GAME_OVER = 3'd5
  } launcher_state_t;

  localparam int NUM_FRAMES    = 10;
  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running game tick counter with a one-cycle strobe on wrap
module tick_gen #(
  parameter int TICK_CYCLES = 3000000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  output logic tick_out
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick_out = (cnt == LAST);

endmodule

// File: rtl/ball_launcher.sv
// rtl/ball_launcher.sv - aim/power button controller driving the ball launch handshake
module ball_launcher
  import bowling_pkg::*;
#(
  parameter int TICK_CYCLES  = 3000000,
  parameter int MAX_LAT      = 6,
  parameter int MIN_POWER    = 2,
  parameter int MAX_POWER    = 12,
  parameter int SETTLE_TICKS = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              btn_in,
  input  logic              ball_done_in,
  input  logic              strike_in,
  output logic [15:0]       speed_x_out,
  output logic [15:0]       speed_y_out,
  output logic              is_vy_neg_out,
  output logic              launch_valid_out,
  output logic signed [7:0] aim_out,
  output logic [7:0]        power_out,
  output logic [2:0]        state_out,
  output logic [3:0]        frame_out,
  output logic              throw_out,
  output logic              game_over_out
);

  localparam logic signed [7:0] AIM_MAX = 8'(MAX_LAT);
  localparam logic signed [7:0] AIM_MIN = 8'(-MAX_LAT);
  localparam logic [7:0] P_MIN = 8'(MIN_POWER);
  localparam logic [7:0] P_MAX = 8'(MAX_POWER);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_TICKS - 1);
  localparam logic [3:0] LAST_FRAME = 4'(NUM_FRAMES - 1);

  launcher_state_t state, state_nxt;

  logic              tick;
  logic              btn_q, done_q;
  logic              press, done_rise;
  logic signed [7:0] aim, aim_step;
  logic              aim_up;
  logic [7:0]        power, power_step;
  logic              power_up;
  logic [7:0]        aim_mag;
  logic [7:0]        settle_cnt;
  logic [3:0]        frame;
  logic              throw_q;
  logic              last_throw, game_end, settle_end;

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .tick_out (tick)
  );

  assign press      = btn_in & ~btn_q;
  assign done_rise  = ball_done_in & ~done_q;
  assign aim_step   = aim_up ? (aim + 8'sd1) : (aim - 8'sd1);
  assign power_step = power_up ? (power + 8'd1) : (power - 8'd1);
  assign aim_mag    = aim[7] ? 8'(-aim) : 8'(aim);
  // A strike on the first throw, or any second throw, closes the frame.
  assign last_throw = throw_q | strike_in;
  assign game_end   = last_throw && (frame == LAST_FRAME);
  assign settle_end = (state == ST_SETTLE) && tick && (settle_cnt == SETTLE_LAST);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= ST_AIM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_AIM:       if (press) state_nxt = ST_POWER;
      ST_POWER:     if (press) state_nxt = ST_LAUNCH;
      ST_LAUNCH:    state_nxt = ST_ROLLING;
      ST_ROLLING:   if (done_rise) state_nxt = ST_SETTLE;
      ST_SETTLE:    if (settle_end) state_nxt = game_end ? ST_GAME_OVER : ST_AIM;
      ST_GAME_OVER: state_nxt = ST_GAME_OVER;
      default:      state_nxt = ST_AIM;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      btn_q         <= 1'b0;
      done_q        <= 1'b0;
      aim           <= 8'sd0;
      aim_up        <= 1'b1;
      power         <= P_MIN;
      power_up      <= 1'b1;
      speed_x_out   <= 16'd0;
      speed_y_out   <= 16'd0;
      is_vy_neg_out <= 1'b0;
      launch_valid_out <= 1'b0;
      settle_cnt    <= 8'd0;
      frame         <= 4'd0;
      throw_q       <= 1'b0;
    end else begin
      btn_q  <= btn_in;
      done_q <= ball_done_in;
      case (state)
        ST_AIM: begin
          // A press on a tick edge freezes the pre-tick value.
          if (tick && !press) begin
            aim <= aim_step;
            if (aim_step == AIM_MAX || aim_step == AIM_MIN) aim_up <= ~aim_up;
          end
        end
        ST_POWER: begin
          if (tick && !press) begin
            power <= power_step;
            if (power_step == P_MAX || power_step == P_MIN) power_up <= ~power_up;
          end
        end
        ST_LAUNCH: begin
          speed_x_out      <= {8'd0, power};
          speed_y_out      <= {8'd0, aim_mag};
          is_vy_neg_out    <= aim[7];
          launch_valid_out <= 1'b1;
        end
        ST_ROLLING: begin
          if (done_rise) begin
            launch_valid_out <= 1'b0;
            settle_cnt       <= 8'd0;
          end
        end
        ST_SETTLE: begin
          if (tick) begin
            if (settle_cnt == SETTLE_LAST) begin
              aim      <= 8'sd0;
              aim_up   <= 1'b1;
              power    <= P_MIN;
              power_up <= 1'b1;
              if (!game_end) begin
                if (last_throw) begin
                  frame   <= frame + 4'd1;
                  throw_q <= 1'b0;
                end else begin
                  throw_q <= 1'b1;
                end
              end
            end else begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign aim_out       = aim;
  assign power_out     = power;
  assign state_out     = state;
  assign frame_out     = frame;
  assign throw_out     = throw_q;
  assign game_over_out = (state == ST_GAME_OVER);

endmodule

// File: doc/ball_launcher.md
# ball_launcher

Player-side launch controller that drives the ball physics block's launch interface. It turns a single debounced button into an aim phase and a power phase, then presents `initial_speed_x`, `initial_speed_y` and `is_vy_neg` with a held `valid` handshake. It waits for the ball's `done`, lets the pins settle, and advances a 10-frame, 2-throw game count. It sits between the input debouncer and the ball block; its HUD outputs feed the renderer.

## Interface
- `TICK_CYCLES`, 3000000: clock cycles per game tick. Equals the ball block's update period.
- `MAX_LAT`, 6: lateral speed magnitude limit in px/tick. Aim sweeps −MAX_LAT..+MAX_LAT.
- `MIN_POWER`, 2: lowest forward speed in px/tick.
- `MAX_POWER`, 12: highest forward speed in px/tick.
- `SETTLE_TICKS`, 4: ticks to wait after `done` before the next throw.
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: reset, synchronous and active-low (one clock; polarity and synchronicity fixed).
- `btn_in` in 1: debounced, synchronous button level.
- `ball_done_in` in 1: ball `done` level.
- `strike_in` in 1: all pins down; sampled in SETTLE.
- `speed_x_out` out 16: drives ball `initial_speed_x`.
- `speed_y_out` out 16: drives ball `initial_speed_y`.
- `is_vy_neg_out` out 1: drives ball `is_vy_neg`.
- `launch_valid_out` out 1: drives ball `valid_in`.
- `aim_out` out 8 signed: live aim value for the HUD.
- `power_out` out 8: live power value for the HUD.
- `state_out` out 3: FSM state encoding.
- `frame_out` out 4: frame number, 0..9.
- `throw_out` out 1: throw within frame, 0 or 1.
- `game_over_out` out 1: game finished.

## Operation
- **Reset values**: state AIM; aim 0, aim direction +; power MIN_POWER, power direction +. All speed outputs 0, `is_vy_neg_out` 0, `launch_valid_out` 0. Frame 0, throw 0, `game_over_out` 0. Tick counter 0, button and done edge registers 0.
- **Tick**: the counter wraps at TICK_CYCLES−1. `tick` is a 1-cycle strobe on the wrap.
- **Button press**: rising edge of `btn_in` (one history register). Presses outside AIM and POWER are ignored.
- **Done event**: rising edge of `ball_done_in` (one history register).
- **AIM**: on each tick, aim steps ±1. Direction reverses when aim reaches ±MAX_LAT, so the sweep is a triangle wave. A press freezes aim and moves to POWER.
- **POWER**: on each tick, power steps ±1 between MIN_POWER and MAX_POWER, also as a triangle wave. A press moves to LAUNCH.
- **LAUNCH** (1 cycle):
  - latch `speed_x_out` = power and `speed_y_out` = |aim|, both zero-extended to 16 bits;
  - latch `is_vy_neg_out` = (aim < 0);
  - set `launch_valid_out` = 1;
  - go to ROLLING.
- **ROLLING**: hold every launch output stable. The ball reads `is_vy_neg` continuously while rolling. On a done event, clear `launch_valid_out`, reset the settle count, and go to SETTLE.
- **SETTLE**: after SETTLE_TICKS ticks, advance the throw:
  - if throw 0 and `strike_in`, or throw 1: go to the next frame with throw 0;
  - otherwise: throw becomes 1;
  - if the frame being closed is frame 9: go to GAME_OVER instead.
  - In all non-terminal cases the next state is AIM. Aim and power reset to their reset values. The speed outputs keep their last values.
- **GAME_OVER**: absorbing state; `game_over_out` = 1. Only reset exits it.
- **State encoding**: AIM 0, POWER 1, LAUNCH 2, ROLLING 3, SETTLE 4, GAME_OVER 5.

## Timing
- Press to `launch_valid_out` high: 2 cycles (edge register, then the LAUNCH cycle).
- **Valid hold**: `launch_valid_out` stays high from LAUNCH until the cycle after the done event. The ball samples `valid` only on its own tick.
- **Relaunch margin**: valid drops ≥ TICK_CYCLES−1 cycles before the ball's next sample, so no double launch occurs.
- **Stale done**: `ball_done_in` may already be 1 at LAUNCH (left over from the previous throw). Only a fresh rising edge ends ROLLING.
- **Simultaneous press and tick in AIM/POWER**: the press wins. The value is frozen at its pre-tick value.
- **Reset mid-roll**: all outputs return to reset values on the next edge, including `launch_valid_out` = 0.

## Structure
- **Package `bowling_pkg`**:
  - `launcher_state_t` enum;
  - `NUM_FRAMES` = 10;
  - `SCREEN_WIDTH` = 1024 and `SCREEN_HEIGHT` = 768, shared with the ball block.
- **Sub-module `tick_gen`**: parameterised TICK_CYCLES counter with a `tick` strobe. It is reusable by the ball block.

## Test plan
All scenarios use TICK_CYCLES = 4.
- **Reset**: hold `rst_n_in` = 0 for 3 cycles → `state_out` = 0, `aim_out` = 0, `power_out` = 2, and every launch output is 0.
- **Left-aimed launch**: press after the aim has gone +6 and back down to −3, then press when power = 9 → `speed_x_out` = 9, `speed_y_out` = 3, `is_vy_neg_out` = 1, `launch_valid_out` = 1 two cycles after the second press.
- **Stale done**: hold `ball_done_in` = 1 through LAUNCH, drop it to 0, then raise it to 1 → valid stays 1 until the rise and clears on the next cycle; `state_out` = 4.
- **Strike**: strike on throw 0 of frame 3, then 4 settle ticks → `frame_out` = 4, `throw_out` = 0. Same sequence without strike → `frame_out` = 3, `throw_out` = 1.
- **Game over**: complete frame 9 throw 1 → `game_over_out` = 1. Later presses and done pulses change nothing.
- **Reset mid-roll**: apply reset with `launch_valid_out` = 1 → `launch_valid_out` = 0 and `frame_out` = 0 on the next edge.
